// File: rtl/musicnote_pkg.sv
// Shared constants for the music note front end: conditioner defaults, note codes and
// period bin boundaries (in clk cycles), so conditioner, detector and bench agree.
package musicnote_pkg;

    localparam int SYNC_STAGES_DEFAULT    = 2;
    localparam int FILT_CYCLES_DEFAULT    = 16;
    localparam int SILENCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [2:0] {
        NOTE_SA  = 3'd0,
        NOTE_RE  = 3'd1,
        NOTE_GA  = 3'd2,
        NOTE_MA  = 3'd3,
        NOTE_PA  = 3'd4,
        NOTE_DHA = 3'd5,
        NOTE_NI  = 3'd6,
        NOTE_HSA = 3'd7
    } note_code_t;

    // Bin edges sit midway between neighbouring just-intonation periods (Sa = 200000 cycles).
    localparam int PERIOD_SA_MAX  = 220000;
    localparam int PERIOD_SA_RE   = 188889;
    localparam int PERIOD_RE_GA   = 168889;
    localparam int PERIOD_GA_MA   = 155000;
    localparam int PERIOD_MA_PA   = 141667;
    localparam int PERIOD_PA_DHA  = 126667;
    localparam int PERIOD_DHA_NI  = 113333;
    localparam int PERIOD_NI_HSA  = 103333;
    localparam int PERIOD_HSA_MIN = 94000;

    function automatic note_code_t period_to_note(input int period);
        note_code_t note;
        if (period >= PERIOD_SA_RE)       note = NOTE_SA;
        else if (period >= PERIOD_RE_GA)  note = NOTE_RE;
        else if (period >= PERIOD_GA_MA)  note = NOTE_GA;
        else if (period >= PERIOD_MA_PA)  note = NOTE_MA;
        else if (period >= PERIOD_PA_DHA) note = NOTE_PA;
        else if (period >= PERIOD_DHA_NI) note = NOTE_DHA;
        else if (period >= PERIOD_NI_HSA) note = NOTE_NI;
        else                              note = NOTE_HSA;
        return note;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by a synchronous reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/waveform_conditioner.sv
// Synchronises and glitch-filters the comparator waveform, emits edge strobes and a silence flag.
// Optional macro GLITCH_CNT_EN builds the rejected-glitch counter; otherwise glitch_count is 0.
module waveform_conditioner
    import musicnote_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int FILT_CYCLES    = FILT_CYCLES_DEFAULT,
    parameter int SILENCE_CYCLES = SILENCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wave_in,
    output logic        wave_out,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        signal_present,
    output logic        silence_pulse,
    output logic [15:0] glitch_count
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int SW = $clog2(SILENCE_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [SW-1:0] SIL_MAX   = SW'(SILENCE_CYCLES);
    localparam logic [SW-1:0] SIL_ONE   = SW'(1);

    logic          synced;
    logic          wave_reg, wave_next;
    logic [FW-1:0] filt_cnt_reg, filt_cnt_next;
    logic          rise_reg, rise_next;
    logic          fall_reg, fall_next;
    logic [SW-1:0] sil_cnt_reg, sil_cnt_next;
    logic          present_reg, present_next;
    logic          silence_reg, silence_next;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (wave_in),
        .q     (synced)
    );

    always_comb begin
        wave_next     = wave_reg;
        filt_cnt_next = '0;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        if (synced != wave_reg) begin
            if (filt_cnt_reg == FILT_LAST) begin
                wave_next = synced;
                rise_next = synced;
                fall_next = ~synced;
            end else begin
                filt_cnt_next = filt_cnt_reg + FILT_ONE;
            end
        end

        // A rise strobe wins over saturation, so a rise on the last count keeps presence.
        if (rise_reg) begin
            sil_cnt_next = '0;
        end else if (sil_cnt_reg == SIL_MAX) begin
            sil_cnt_next = sil_cnt_reg;
        end else begin
            sil_cnt_next = sil_cnt_reg + SIL_ONE;
        end
        present_next = (sil_cnt_next < SIL_MAX);
        silence_next = present_reg & ~present_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wave_reg     <= 1'b0;
            filt_cnt_reg <= '0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            sil_cnt_reg  <= SIL_MAX;
            present_reg  <= 1'b0;
            silence_reg  <= 1'b0;
        end else begin
            wave_reg     <= wave_next;
            filt_cnt_reg <= filt_cnt_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
            sil_cnt_reg  <= sil_cnt_next;
            present_reg  <= present_next;
            silence_reg  <= silence_next;
        end
    end

`ifdef GLITCH_CNT_EN
    logic [15:0] glitch_reg;
    logic        glitch_hit;

    // An excursion that was being counted but collapsed before committing.
    assign glitch_hit = (filt_cnt_reg != '0) && (synced == wave_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_reg <= '0;
        end else if (glitch_hit && (glitch_reg != 16'hFFFF)) begin
            glitch_reg <= glitch_reg + 16'd1;
        end
    end

    assign glitch_count = glitch_reg;
`else
    assign glitch_count = 16'd0;
`endif

    assign wave_out       = wave_reg;
    assign rise_pulse     = rise_reg;
    assign fall_pulse     = fall_reg;
    assign signal_present = present_reg;
    assign silence_pulse  = silence_reg;

endmodule
